// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode, register ID and status constants
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [3:0] RSP_ID  = 4'd4;
    localparam logic [3:0] RNONE   = 4'd15;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

endpackage

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - decode/write-back bundle between the SEQ datapath and the register file
interface writeback_regfile_if #(
    parameter int WIDTH = 64
);
    logic [3:0]       icode;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic             cnd;
    logic [WIDTH-1:0] valE;
    logic [WIDTH-1:0] valM;
    logic             wb_en;
    logic [2:0]       stat_in;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [3:0]       dbg_addr;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] dbg_data;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [2:0]       stat_out;
    logic             halted;

    modport master (
        output icode, rA, rB, cnd, valE, valM, wb_en, stat_in, srcA, srcB, dbg_addr,
        input  valA, valB, dbg_data, dstE, dstM, stat_out, halted
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, wb_en, stat_in, srcA, srcB, dbg_addr,
        output valA, valB, dbg_data, dstE, dstM, stat_out, halted
    );

endinterface

// File: rtl/writeback_regfile_regfile_2r2w.sv
// rtl/writeback_regfile_regfile_2r2w.sv - 15-entry register storage, three read ports, two write ports
module regfile_2r2w #(
    parameter int         WIDTH = 64,
    parameter int         NREG  = 15,
    parameter logic [3:0] RNONE = 4'd15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:0]       addr_e,
    input  logic [WIDTH-1:0] data_e,
    input  logic [3:0]       addr_m,
    input  logic [WIDTH-1:0] data_m,
    input  logic [3:0]       ra_a,
    output logic [WIDTH-1:0] rd_a,
    input  logic [3:0]       ra_b,
    output logic [WIDTH-1:0] rd_b,
    input  logic [3:0]       ra_d,
    output logic [WIDTH-1:0] rd_d
);

    logic [WIDTH-1:0] regs [NREG];

    // The M write is issued last so it overrides E when both target the same ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            if (addr_e != RNONE) begin
                regs[addr_e] <= data_e;
            end
            if (addr_m != RNONE) begin
                regs[addr_m] <= data_m;
            end
        end
    end

    assign rd_a = (ra_a == RNONE) ? '0 : regs[ra_a];
    assign rd_b = (ra_b == RNONE) ? '0 : regs[ra_b];
    assign rd_d = (ra_d == RNONE) ? '0 : regs[ra_d];

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - SEQ write-back: destination select, sticky status and register commit
module writeback_regfile #(
    parameter int         WIDTH  = 64,
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = y86_pkg::RSP_ID,
    parameter logic [3:0] RNONE  = y86_pkg::RNONE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    writeback_regfile_if.slave   wb
);
    import y86_pkg::*;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [2:0] stat_q;
    logic       halted;
    logic       commit;

    always_comb begin
        dst_e = RNONE;
        case (wb.icode)
            IRRMOVQ:                     dst_e = wb.cnd ? wb.rB : RNONE;
            IIRMOVQ, IOPQ:               dst_e = wb.rB;
            ICALL, IRET, IPUSHQ, IPOPQ:  dst_e = RSP_ID;
            default:                     dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        if (wb.icode == IMRMOVQ || wb.icode == IPOPQ) begin
            dst_m = wb.rA;
        end
    end

    // Status only follows valid instructions and freezes at the first non-AOK one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= SAOK;
        end else if (wb.wb_en && !halted) begin
            stat_q <= wb.stat_in;
        end
    end

    assign halted = (stat_q != SAOK);
    assign commit = wb.wb_en && (wb.stat_in == SAOK) && !halted;

    regfile_2r2w #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .RNONE (RNONE)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (commit),
        .addr_e (dst_e),
        .data_e (wb.valE),
        .addr_m (dst_m),
        .data_m (wb.valM),
        .ra_a   (wb.srcA),
        .rd_a   (wb.valA),
        .ra_b   (wb.srcB),
        .rd_b   (wb.valB),
        .ra_d   (wb.dbg_addr),
        .rd_d   (wb.dbg_data)
    );

    assign wb.dstE     = dst_e;
    assign wb.dstM     = dst_m;
    assign wb.stat_out = stat_q;
    assign wb.halted   = halted;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - scoreboard bench for writeback_regfile
module tb_writeback_regfile;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb [$];
    logic [63:0] obs [$];
    int   n_cmp;
    int   n_bad;

    writeback_regfile_if #(.WIDTH(64)) wb ();

    writeback_regfile #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [63:0] e, input logic [63:0] o);
        sb.push_back('{tag: tag, exp: e});
        obs.push_back(o);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] ve, input logic [63:0] vm,
                         input logic en, input logic [2:0] st);
        wb.icode = ic; wb.rA = ra; wb.rB = rb; wb.cnd = c;
        wb.valE = ve; wb.valM = vm; wb.wb_en = en; wb.stat_in = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wb.wb_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [63:0] o;
        for (int i = 0; i < 16; i++) begin
            wb.srcA = 4'(i); wb.srcB = 4'(i); wb.dbg_addr = 4'(i);
            #1;
            expect_val($sformatf("rst_valA_%0d", i), 64'h0, wb.valA);
            expect_val($sformatf("rst_valB_%0d", i), 64'h0, wb.valB);
            expect_val($sformatf("rst_dbg_%0d", i), 64'h0, wb.dbg_data);
        end
        expect_val("rst_stat", 64'd1, 64'(wb.stat_out));
        expect_val("rst_halted", 64'd0, 64'(wb.halted));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_dst();
        logic [3:0] ics [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        logic [3:0] de  [12] = '{4'd15, 4'd15, 4'd9, 4'd9, 4'd15, 4'd15, 4'd9, 4'd15, 4'd4, 4'd4, 4'd4, 4'd4};
        logic [3:0] dm  [12] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd6, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd6};
        exp_t e;
        logic [63:0] o;
        for (int i = 0; i < 12; i++) begin
            drive(ics[i], 4'd6, 4'd9, 1'b1, 64'h0, 64'h0, 1'b0, 3'd1);
            #1;
            expect_val($sformatf("dstE_ic%0d", i), 64'(de[i]), 64'(wb.dstE));
            expect_val($sformatf("dstM_ic%0d", i), 64'(dm[i]), 64'(wb.dstM));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_irmovq();
        exp_t e;
        logic [63:0] o;
        drive(4'd3, 4'd15, 4'd2, 1'b0, 64'h1234, 64'h0, 1'b1, 3'd1);
        wb.srcA = 4'd2;
        #1;
        expect_val("irmov_dstE", 64'd2, 64'(wb.dstE));
        expect_val("irmov_dstM", 64'd15, 64'(wb.dstM));
        expect_val("irmov_pre_edge", 64'h0, wb.valA);
        step();
        expect_val("irmov_valA", 64'h1234, wb.valA);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_cmov();
        exp_t e;
        logic [63:0] o;
        wb.dbg_addr = 4'd3;
        drive(4'd2, 4'd0, 4'd3, 1'b0, 64'h55, 64'h0, 1'b1, 3'd1);
        #1;
        expect_val("cmov_nc_dstE", 64'd15, 64'(wb.dstE));
        step();
        expect_val("cmov_nc_reg3", 64'h0, wb.dbg_data);
        drive(4'd2, 4'd0, 4'd3, 1'b1, 64'h55, 64'h0, 1'b1, 3'd1);
        #1;
        expect_val("cmov_c_dstE", 64'd3, 64'(wb.dstE));
        step();
        expect_val("cmov_c_reg3", 64'h55, wb.dbg_data);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_popq();
        exp_t e;
        logic [63:0] o;
        wb.srcA = 4'd4; wb.srcB = 4'd3;
        drive(4'd11, 4'd4, 4'd15, 1'b0, 64'h108, 64'hABCD, 1'b1, 3'd1);
        #1;
        expect_val("poprsp_dstE", 64'd4, 64'(wb.dstE));
        expect_val("poprsp_dstM", 64'd4, 64'(wb.dstM));
        step();
        expect_val("poprsp_reg4", 64'hABCD, wb.valA);
        drive(4'd11, 4'd3, 4'd15, 1'b0, 64'h108, 64'h77, 1'b1, 3'd1);
        step();
        expect_val("poprbx_reg4", 64'h108, wb.valA);
        expect_val("poprbx_reg3", 64'h77, wb.valB);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [63:0] o;
        wb.srcA = 4'd7; wb.srcB = 4'd8;
        drive(4'd3, 4'd15, 4'd7, 1'b0, 64'hA5A5_0000_0000_0001, 64'h0, 1'b1, 3'd1);
        @(posedge clk); #1;
        drive(4'd6, 4'd7, 4'd8, 1'b0, 64'h0000_FFFF_0000_0002, 64'h0, 1'b1, 3'd1);
        #1;
        expect_val("b2b_r7_mid", 64'hA5A5_0000_0000_0001, wb.valA);
        expect_val("b2b_r8_pre", 64'h0, wb.valB);
        step();
        expect_val("b2b_r8_post", 64'h0000_FFFF_0000_0002, wb.valB);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_wb_idle();
        exp_t e;
        logic [63:0] o;
        wb.dbg_addr = 4'd5;
        drive(4'd3, 4'd15, 4'd5, 1'b0, 64'h99, 64'h0, 1'b0, 3'd2);
        repeat (3) @(posedge clk);
        #1;
        expect_val("idle_reg5", 64'h0, wb.dbg_data);
        expect_val("idle_stat", 64'd1, 64'(wb.stat_out));
        expect_val("idle_halted", 64'd0, 64'(wb.halted));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        logic [63:0] o;
        wb.dbg_addr = 4'd1;
        drive(4'd0, 4'd15, 4'd15, 1'b0, 64'h0, 64'h0, 1'b1, 3'd2);
        step();
        expect_val("hlt_stat", 64'd2, 64'(wb.stat_out));
        expect_val("hlt_halted", 64'd1, 64'(wb.halted));
        drive(4'd6, 4'd0, 4'd1, 1'b0, 64'h7, 64'h0, 1'b1, 3'd1);
        step();
        expect_val("hlt_reg1", 64'h0, wb.dbg_data);
        expect_val("hlt_stat_frozen", 64'd2, 64'(wb.stat_out));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [63:0] o;
        wb.srcA = 4'd4; wb.srcB = 4'd7; wb.dbg_addr = 4'd2;
        drive(4'd3, 4'd15, 4'd4, 1'b0, 64'hDEAD, 64'h0, 1'b1, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("mid_valA", 64'h0, wb.valA);
        expect_val("mid_valB", 64'h0, wb.valB);
        expect_val("mid_dbg", 64'h0, wb.dbg_data);
        expect_val("mid_stat", 64'd1, 64'(wb.stat_out));
        expect_val("mid_halted", 64'd0, 64'(wb.halted));
        @(posedge clk); #1;
        expect_val("mid_hold_valA", 64'h0, wb.valA);
        wb.wb_en = 1'b0;
        rst_n = 1'b1;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    task automatic test_adr();
        exp_t e;
        logic [63:0] o;
        wb.dbg_addr = 4'd6;
        drive(4'd5, 4'd6, 4'd15, 1'b0, 64'h0, 64'hDEAD, 1'b1, 3'd3);
        #1;
        expect_val("adr_dstM", 64'd6, 64'(wb.dstM));
        step();
        expect_val("adr_reg6", 64'h0, wb.dbg_data);
        expect_val("adr_stat", 64'd3, 64'(wb.stat_out));
        expect_val("adr_halted", 64'd1, 64'(wb.halted));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
            if (o !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.exp); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(4'd1, 4'd15, 4'd15, 1'b0, 64'h0, 64'h0, 1'b0, 3'd1);
        wb.srcA = 4'd15; wb.srcB = 4'd15; wb.dbg_addr = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_dst();
        test_irmovq();
        test_cmov();
        test_popq();
        test_back_to_back();
        test_wb_idle();
        test_halt();
        test_reset_mid();
        test_adr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back end of the SEQ register-file interface. The decode stage produces read addresses srcA/srcB; this block performs the register reads against them.
- Computes destination IDs dstE/dstM from icode/rA/rB/cnd and commits valE/valM into the 15-entry Y86-64 register file on the rising clock edge.
- Latches the processor halt/exception status so the datapath stops committing after a non-AOK instruction.

Parameters:
- WIDTH, 64, data width of each register and of valE/valM/valA/valB.
- NREG, 15, number of architectural registers (IDs 0..14).
- RSP_ID, 4, register ID of %rsp.
- RNONE, 15, "no register" ID; never written, reads return 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- icode  input  4  instruction code of the retiring instruction.
- rA  input  4  rA field.
- rB  input  4  rB field.
- cnd  input  1  condition result from execute; gates the cmovXX write.
- valE  input  WIDTH  ALU result.
- valM  input  WIDTH  memory read data.
- wb_en  input  1  instruction valid this cycle; no commit when 0.
- stat_in  input  3  instruction status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- srcA  input  4  read address A, from decode.
- srcB  input  4  read address B, from decode.
- valA  output  WIDTH  register[srcA], 0 if srcA==RNONE.
- valB  output  WIDTH  register[srcB], 0 if srcB==RNONE.
- dstE  output  4  computed E destination.
- dstM  output  4  computed M destination.
- stat_out  output  3  sticky processor status.
- halted  output  1  1 once stat_out != AOK.
- dbg_addr  input  4  debug read address.
- dbg_data  output  WIDTH  register[dbg_addr], 0 for RNONE.

Behaviour:
- dstE (combinational):
  - icode 2 -> rB if cnd=1, else RNONE.
  - icode 3 or 6 -> rB.
  - icode 8, 9, 10 or 11 -> RSP_ID.
  - all other icodes -> RNONE.
- dstM (combinational): icode 5 or 11 -> rA; otherwise RNONE.
- Reads are combinational and return pre-edge contents. There is no write-to-read bypass in the same cycle, matching SEQ ordering.
- Commit condition: commit = wb_en & (stat_in==AOK) & ~halted.
- On each rising clk edge with commit=1:
  - if dstE != RNONE, reg[dstE] <= valE;
  - if dstM != RNONE, reg[dstM] <= valM.
- Collision: if dstE==dstM and neither is RNONE, valM wins, and exactly one write occurs (popq %rsp semantics).
- Out-of-range rA/rB values of 15 map to RNONE and are ignored. No illegal IDs exist in 4 bits.
- Status:
  - On a rising edge with wb_en=1 and halted=0, stat_out <= stat_in.
  - Once stat_out != AOK, halted=1 and stat_out freezes; further wb_en has no effect until reset.
  - The registers of a HLT/ADR/INS instruction are not written.
- Reset (rst_n=0, asynchronous):
  - all 15 registers clear to 0;
  - stat_out = AOK (1);
  - halted = 0.
  - Outputs valA/valB/dbg_data then read 0. dstE/dstM remain combinational.
- Reset deasserting: synchronous release is the integrator's responsibility. The first commit can occur on the first edge after rst_n rises.
- Reset asserted mid-cycle while wb_en=1: no write occurs and registers read 0 immediately.
- Latency:
  - write-to-read is 1 cycle: a value committed at edge N is visible on valA/valB after edge N;
  - dstE/dstM/valA/valB are 0-cycle combinational.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11);
  - register IDs RSP_ID, RNONE;
  - status codes SAOK, SHLT, SADR, SINS.
- One natural sub-module, regfile_2r2w: the 15x WIDTH storage with async clear, three read ports, two write ports and the M-over-E priority.
- The top level holds the dst selection and the status latch.

Test Plan:
- Reset, then read all IDs 0..15 -> all 0. Assert rst_n=0 mid-run after writes -> every read returns 0 immediately.
- irmovq (icode 3, rB=2, valE=0x1234, AOK, wb_en) -> dstE=2, dstM=15. Next cycle srcA=2 -> valA=0x1234. The write is not visible before the edge.
- cmovXX (icode 2, rB=3, valE=0x55): cnd=0 -> reg3 unchanged, dstE=15; cnd=1 -> reg3=0x55.
- popq %rsp (icode 11, rA=4, valE=0x108, valM=0xABCD) -> dstE=dstM=4, reg4=0xABCD. popq %rbx (rA=3) -> reg4=0x108 and reg3=valM in the same edge.
- halt (icode 0, stat_in=HLT) -> stat_out=2, halted=1. A later OPq with rB=1, valE=7, stat AOK -> reg1 unchanged, stat_out stays 2.
- ADR status on mrmovq (icode 5, rA=6) -> reg6 not written, halted=1. wb_en=0 cycles between instructions -> no register or status change.
